// File: rtl/transmissor_dual_rail_if.sv
// Interface bundling the clocked token port, the dual-rail outputs, the async ack
// and the status signals of transmissor_dual_rail.
// master: the upstream producer / test side. slave: the bridge itself.
interface transmissor_dual_rail_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_sub;
    logic             in_ready;
    logic [7:0]       a_dr;
    logic [7:0]       b_dr;
    logic [1:0]       sub_dr;
    logic             ack_in;
    logic             busy;
    logic [CNT_W-1:0] tx_count;
    logic             err;

    modport master (
        output in_valid, in_a, in_b, in_sub, ack_in,
        input  in_ready, a_dr, b_dr, sub_dr, busy, tx_count, err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, ack_in,
        output in_ready, a_dr, b_dr, sub_dr, busy, tx_count, err
    );
endinterface

// File: rtl/transmissor_dual_rail.sv
// transmissor_dual_rail: synchronous-to-asynchronous bridge feeding a dual-rail,
// 4-phase (return-to-zero) ALU pipeline. Each accepted binary token becomes one
// dual-rail codeword (1 -> 10, 0 -> 01), held until the pipeline acks, then
// replaced by the all-zero spacer until the ack returns low.
// Optional feature: define TX_TIMEOUT_EN to add an ack-wait watchdog that
// moves to a sticky ERR state (exit only by rst) after TIMEOUT_CYCLES cycles.
module transmissor_dual_rail #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    transmissor_dual_rail_if.slave  bus
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

`ifdef TX_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_SPACER, S_ERR} state_t;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_SPACER} state_t;
`endif

    // Parameter sanity: a one-flop synchronizer is not metastability safe.
    generate
        if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("transmissor_dual_rail: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic [SETTLE_W-1:0]    r_settle_cnt;
    logic                   w_settled;
    logic [7:0]             r_a_dr;
    logic [7:0]             r_b_dr;
    logic [1:0]             r_sub_dr;
    logic [7:0]             w_a_code;
    logic [7:0]             w_b_code;
    logic [1:0]             w_sub_code;
    logic                   w_in_ready;
    logic                   w_load;
    logic                   w_done;
    logic [CNT_W-1:0]       r_tx_count;

    // Ack synchronizer chain; all stages clear on reset.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the raw asynchronous ack.
                always_ff @(posedge clk) begin
                    if (rst) r_ack_sync[0] <= 1'b0;
                    else     r_ack_sync[0] <= bus.ack_in;
                end
            end else begin : g_rest
                // Later stages resolve metastability of the previous one.
                always_ff @(posedge clk) begin
                    if (rst) r_ack_sync[gi] <= 1'b0;
                    else     r_ack_sync[gi] <= r_ack_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // After reset the chain holds zeros that say nothing about the real ack, so
    // the bridge refuses tokens until the chain has refilled from ack_in.
    always_ff @(posedge clk) begin
        if (rst)             r_settle_cnt <= '0;
        else if (!w_settled) r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
    end

    assign w_settled = (r_settle_cnt == SETTLE_W'(SYNC_STAGES));

    // Dual-rail encoding of the incoming operands: bit i -> rails [2i+1:2i].
    generate
        for (gi = 0; gi < 4; gi++) begin : g_enc
            assign w_a_code[2*gi+1 -: 2] = bus.in_a[gi] ? 2'b10 : 2'b01;
            assign w_b_code[2*gi+1 -: 2] = bus.in_b[gi] ? 2'b10 : 2'b01;
        end
    endgenerate

    assign w_sub_code = bus.in_sub ? 2'b10 : 2'b01;

`ifdef TX_TIMEOUT_EN
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;

    // Wait counter: clears on any state change, counts cycles waiting on ack.
    always_ff @(posedge clk) begin
        if (rst)                                         r_wait_cnt <= '0;
        else if (w_state_next != r_state)                r_wait_cnt <= '0;
        else if (r_state == S_DATA || r_state == S_SPACER) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end

    // Sticky error flag, raised on entry to ERR.
    always_ff @(posedge clk) begin
        if (rst)                      r_err <= 1'b0;
        else if (w_state_next == S_ERR) r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    // Next-state logic: 4-phase handshake sequencing and token acceptance.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A stale or glitching ack blocks acceptance.
                w_in_ready = w_settled && !w_ack_s;
                if (bus.in_valid && w_in_ready) begin
                    w_state_next = S_DATA;
                    w_load       = 1'b1;
                end
            end
            S_DATA: begin
                // An ack that drops again before sampling high keeps the codeword.
                if (w_ack_s) w_state_next = S_SPACER;
            end
            S_SPACER: begin
                if (!w_ack_s) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
`ifdef TX_TIMEOUT_EN
        if ((r_state == S_DATA || r_state == S_SPACER) &&
            r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
            w_state_next = S_ERR;
            w_done       = 1'b0;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Rail registers: load the codeword on accept, hold in DATA, spacer otherwise,
    // so an edge only ever moves between spacer and a full codeword.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_dr   <= 8'h00;
            r_b_dr   <= 8'h00;
            r_sub_dr <= 2'b00;
        end else if (w_load) begin
            r_a_dr   <= w_a_code;
            r_b_dr   <= w_b_code;
            r_sub_dr <= w_sub_code;
        end else if (w_state_next != S_DATA) begin
            r_a_dr   <= 8'h00;
            r_b_dr   <= 8'h00;
            r_sub_dr <= 2'b00;
        end
    end

    // Completed-token counter, wraps silently.
    always_ff @(posedge clk) begin
        if (rst)         r_tx_count <= '0;
        else if (w_done) r_tx_count <= r_tx_count + CNT_W'(1);
    end

    assign bus.in_ready = w_in_ready && !rst;
    assign bus.a_dr     = r_a_dr;
    assign bus.b_dr     = r_b_dr;
    assign bus.sub_dr   = r_sub_dr;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.tx_count = r_tx_count;

endmodule

// File: tb/tb_transmissor_dual_rail.sv
// Testbench for transmissor_dual_rail: vector table of operands with hand-computed
// codewords, a scoreboard queue filled on acceptance and drained when the rails
// show data, a C-element ack model, and hand-written handshake corner cases.
module tb_transmissor_dual_rail;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    transmissor_dual_rail_if #(.CNT_W(CNT_W)) bus();

    transmissor_dual_rail #(
        .SYNC_STAGES(2),
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Ack source: C-element model of the first async stage, or a manual level.
    logic ack_auto = 1'b1;
    logic ack_man  = 1'b0;
    logic ack_c    = 1'b0;
    assign bus.ack_in = ack_auto ? ack_c : ack_man;

    function automatic bit rails_all_valid(input logic [17:0] r);
        for (int i = 0; i < 9; i++) if (r[2*i +: 2] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rails_all_valid({bus.a_dr, bus.b_dr, bus.sub_dr}))   ack_c <= 1'b1;
        else if ({bus.a_dr, bus.b_dr, bus.sub_dr} == 18'd0)      ack_c <= 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] s;
        int         cyc;
    } sb_t;
    sb_t sbq[$];

    logic [7:0]  cur_ea, cur_eb;
    logic [1:0]  cur_es;
    logic [17:0] prev_rails = 18'd0;
    int v11 = 0, vmix = 0, vbusy = 0, vorphan = 0;

    always @(negedge clk) begin
        logic [17:0] rails;
        sb_t e;
        rails = {bus.a_dr, bus.b_dr, bus.sub_dr};
        for (int i = 0; i < 9; i++) if (rails[2*i +: 2] == 2'b11) v11++;
        if (prev_rails != 18'd0 && rails != 18'd0 && rails != prev_rails) vmix++;
        if (bus.in_ready && bus.busy) vbusy++;
        if (prev_rails == 18'd0 && rails != 18'd0) begin
            if (sbq.size() == 0) begin
                vorphan++;
            end else begin
                e = sbq.pop_front();
                check("sb_a_dr", {24'd0, bus.a_dr}, {24'd0, e.a});
                check("sb_b_dr", {24'd0, bus.b_dr}, {24'd0, e.b});
                check("sb_sub_dr", {30'd0, bus.sub_dr}, {30'd0, e.s});
                check("sb_latency_cycle", cyc, e.cyc);
            end
        end
        if (!rst && bus.in_valid && bus.in_ready) begin
            e.a = cur_ea; e.b = cur_eb; e.s = cur_es; e.cyc = cyc + 1;
            sbq.push_back(e);
        end
        prev_rails = rails;
    end

    function automatic logic [7:0] enc4(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    // Present a token and wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] es,
                        input bit keep_valid);
        bit ok;
        bus.in_a = a; bus.in_b = b; bus.in_sub = s;
        cur_ea = ea; cur_eb = eb; cur_es = es;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.busy) begin ok = 1'b1; break; end
        end
        if (!ok) check(name, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [1:0] es;
    } vec_t;
    vec_t vecs[6];

    int exp_count;
    int bad;
    bit found;

    initial begin
        vecs[0] = '{4'h5, 4'hF, 1'b1, 8'h66, 8'hAA, 2'b10};
        vecs[1] = '{4'h0, 4'h0, 1'b0, 8'h55, 8'h55, 2'b01};
        vecs[2] = '{4'hA, 4'h3, 1'b0, 8'h99, 8'h5A, 2'b01};
        vecs[3] = '{4'hF, 4'h0, 1'b1, 8'hAA, 8'h55, 2'b10};
        vecs[4] = '{4'h8, 4'h1, 1'b0, 8'h95, 8'h56, 2'b01};
        vecs[5] = '{4'h7, 4'hE, 1'b1, 8'h6A, 8'hA9, 2'b10};

        bus.in_valid = 1'b0; bus.in_a = 4'h0; bus.in_b = 4'h0; bus.in_sub = 1'b0;
        cur_ea = 8'h00; cur_eb = 8'h00; cur_es = 2'b00;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_dr", {24'd0, bus.a_dr}, 32'h0);
        check("rst_b_dr", {24'd0, bus.b_dr}, 32'h0);
        check("rst_sub_dr", {30'd0, bus.sub_dr}, 32'h0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        check("rst_tx_count", {24'd0, bus.tx_count}, 32'h0);
        check("rst_err", {31'd0, bus.err}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Vector table with C-element ack
        exp_count = 0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ea, vecs[i].eb, vecs[i].es, 1'b0);
            check($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'd1);
            check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
            wait_idle($sformatf("vec%0d_idle_timeout", i));
            check($sformatf("vec%0d_rails_spacer", i), {14'd0, bus.a_dr, bus.b_dr, bus.sub_dr}, 32'd0);
            exp_count++;
            check($sformatf("vec%0d_tx_count", i), {24'd0, bus.tx_count}, exp_count);
        end

        // Ack held low for 1000 cycles
        ack_auto = 1'b0; ack_man = 1'b0;
        send(4'h5, 4'hF, 1'b1, 8'h66, 8'hAA, 2'b10, 1'b0);
        bad = 0;
`ifdef TX_TIMEOUT_EN
        repeat (1000) @(negedge clk);
        check("timeout_err", {31'd0, bus.err}, 32'd1);
        check("timeout_rails", {14'd0, bus.a_dr, bus.b_dr, bus.sub_dr}, 32'd0);
        check("timeout_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        do_reset();
        exp_count = 0;
`else
        repeat (1000) begin
            @(negedge clk);
            if ({bus.a_dr, bus.b_dr, bus.sub_dr} != {8'h66, 8'hAA, 2'b10} || bus.in_ready) bad++;
        end
        check("hold_1000_bad_cycles", bad, 32'd0);
        check("hold_err", {31'd0, bus.err}, 32'd0);
        @(posedge clk); #1;
        ack_auto = 1'b1;
        wait_idle("hold_release_timeout");
        exp_count++;
        check("hold_tx_count", {24'd0, bus.tx_count}, exp_count);
`endif

        // Reset mid-DATA while ack is high
        ack_auto = 1'b0; ack_man = 1'b0;
        send(4'hA, 4'h3, 1'b0, 8'h99, 8'h5A, 2'b01, 1'b0);
        ack_man = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("middata_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("rstdata_rails", {14'd0, bus.a_dr, bus.b_dr, bus.sub_dr}, 32'd0);
        check("rstdata_tx_count", {24'd0, bus.tx_count}, 32'd0);
        check("rstdata_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_count = 0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.in_ready) bad++;
        end
        check("stale_ack_ready_cycles", bad, 32'd0);
        @(posedge clk); #1 ack_man = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin found = 1'b1; break; end
        end
        check("ready_after_ack_drop", {31'd0, found}, 32'd1);
        @(posedge clk); #1;

        // One-cycle ack pulse in IDLE
        ack_man = 1'b1;
        @(posedge clk); #1 ack_man = 1'b0;
        @(posedge clk); #1;
        bus.in_a = 4'h3; bus.in_b = 4'hC; bus.in_sub = 1'b1;
        cur_ea = 8'h5A; cur_eb = 8'hA5; cur_es = 2'b10;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("pulse_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("pulse_rails", {14'd0, bus.a_dr, bus.b_dr, bus.sub_dr}, 32'd0);
        check("pulse_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("pulse_rails_later", {14'd0, bus.a_dr, bus.b_dr, bus.sub_dr}, 32'd0);
        check("pulse_sb_empty", sbq.size(), 32'd0);
        @(posedge clk); #1;

        // 300 back-to-back tokens with in_valid held high
        do_reset();
        ack_auto = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ra, rb;
            logic       rs;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, enc4(ra), enc4(rb), rs ? 2'b10 : 2'b01, 1'b1);
        end
        bus.in_valid = 1'b0;
        wait_idle("wrap_idle_timeout");
        check("wrap_tx_count", {24'd0, bus.tx_count}, 32'd44);

        // Global invariants
        check("rails_11_seen", v11, 32'd0);
        check("data_to_data_edges", vmix, 32'd0);
        check("ready_while_busy", vbusy, 32'd0);
        check("unexpected_codewords", vorphan, 32'd0);
        check("sb_leftover", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before limit");
        $fatal(1, "timeout");
    end
endmodule
